// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU sequencer: state encoding, opcode/funct
// constants and the instruction-class encoding.
package cpu_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_PC1    = 3'd6;
    localparam logic [2:0] ST_PC2    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_PC1    = ST_PC1,
        S_PC2    = ST_PC2
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [3:0] {
        CLS_RTYPE   = 4'd0,
        CLS_ITYPE   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BR      = 4'd4,
        CLS_J       = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JR      = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_e;

endpackage

// File: rtl/instr_classifier.sv
// Combinational opcode/funct to instruction-class decoder; shared with the
// hazard logic, so it carries no state.
module instr_classifier
    import cpu_seq_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_SPECIAL: begin
                if (funct_i == FN_JR)
                    cls_o = CLS_JR;
                else if (funct_i == FN_JALR)
                    cls_o = CLS_JALR;
                else
                    cls_o = CLS_RTYPE;
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_o = CLS_BR;
            OP_J:   cls_o = CLS_J;
            OP_JAL: cls_o = CLS_JAL;
            OP_LW:  cls_o = CLS_LOAD;
            OP_SW:  cls_o = CLS_STORE;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: cls_o = CLS_ITYPE;
            default: cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, classify, sequence ALU/memory/writeback,
// then issue one or two PC-unit step pulses per instruction.
//
// state  | meaning
// IDLE   | post-reset, moves to FETCH next cycle
// FETCH  | request instruction; holds (quiet) while halt is high
// DECODE | ir_load pulse, class already latched
// EXEC   | alu_start on entry, wait for alu_done
// MEM    | data-memory access, wait for mem_ready
// WB     | register-file write strobe
// PC1    | first PC step (branch/jump two-phase resolve)
// PC2    | final PC step, instruction retires
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic             alu_done,
    input  logic             mem_ready,
    output logic             fetch_req,
    output logic             ir_load,
    output logic             alu_start,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_step,
    output logic             busy,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired
);

    state_e       state_q, state_d;
    instr_class_e class_q;
    instr_class_e cls_w;
    logic         load_w;
    logic [RET_W-1:0] retired_q;

    logic fetch_req_q, ir_load_q, alu_start_q, mem_req_q;
    logic mem_we_q, reg_we_q, pc_step_q, busy_q;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    instr_classifier u_classifier (
        .opcode_i (instr[31:26]),
        .funct_i  (instr[5:0]),
        .cls_o    (cls_w)
    );

    assign load_w = (state_q == S_FETCH) && instr_valid && !halt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (load_w) state_d = S_DECODE;
            S_DECODE: begin
                case (class_q)
                    CLS_JAL:              state_d = S_PC1;
                    CLS_J, CLS_ILLEGAL:   state_d = S_PC2;
                    default:              state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (alu_done) begin
                    case (class_q)
                        CLS_RTYPE, CLS_ITYPE: state_d = S_WB;
                        CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                        default:              state_d = S_PC1;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ready)
                    state_d = (class_q == CLS_STORE) ? S_PC2 : S_WB;
            end
            S_WB:     state_d = S_PC2;
            S_PC1:    state_d = S_PC2;
            S_PC2:    state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is glitch-free and
    // lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            class_q     <= CLS_ILLEGAL;
            retired_q   <= '0;
            fetch_req_q <= 1'b0;
            ir_load_q   <= 1'b0;
            alu_start_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            pc_step_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_w)
                class_q <= cls_w;
            if (state_q == S_PC2)
                retired_q <= retired_q + RET_W'(1);
            fetch_req_q <= (state_d == S_FETCH) && !halt;
            ir_load_q   <= (state_d == S_DECODE);
            alu_start_q <= (state_d == S_EXEC) && (state_q != S_EXEC);
            mem_req_q   <= (state_d == S_MEM);
            mem_we_q    <= (state_d == S_MEM) && (class_q == CLS_STORE);
            reg_we_q    <= (state_d == S_WB);
            pc_step_q   <= (state_d == S_PC1) || (state_d == S_PC2);
            busy_q      <= !((state_d == S_IDLE) || ((state_d == S_FETCH) && halt));
        end
    end

    assign fetch_req = fetch_req_q;
    assign ir_load   = ir_load_q;
    assign alu_start = alu_start_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign reg_we    = reg_we_q;
    assign pc_step   = pc_step_q;
    assign busy      = busy_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: each issued instruction queues its
// expected per-cycle trace, a negedge monitor pops and compares.
module tb_cpu_sequencer;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3;
    localparam logic [2:0] MEM = 3'd4, WB = 3'd5, PC1 = 3'd6, PC2 = 3'd7;

    // {ir_load, alu_start, mem_req, mem_we, reg_we, pc_step, busy, fetch_req}
    localparam logic [7:0] O_IRL = 8'h80, O_ALU = 8'h40, O_MRQ = 8'h20, O_MWE = 8'h10;
    localparam logic [7:0] O_RWE = 8'h08, O_PCS = 8'h04, O_BSY = 8'h02, O_FRQ = 8'h01;

    localparam int K_ALU = 0, K_BR = 1, K_LOAD = 2, K_STORE = 3, K_JAL = 4, K_ONE = 5;

    typedef struct {
        logic [2:0] st;
        logic [7:0] outs;
        logic       ad;
        logic       mr;
    } step_t;

    typedef struct {
        logic [2:0]  st;
        logic [7:0]  outs;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, halt, instr_valid, alu_done, mem_ready;
    logic [31:0] instr;
    logic        fetch_req, ir_load, alu_start, mem_req, mem_we, reg_we, pc_step, busy;
    logic [2:0]  state;
    logic [31:0] retired;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [31:0] exp_ret = 0;
    exp_t exp_q[$];

    cpu_sequencer #(.RET_W(32)) dut (
        .clk(clk), .rst(rst), .halt(halt), .instr_valid(instr_valid), .instr(instr),
        .alu_done(alu_done), .mem_ready(mem_ready), .fetch_req(fetch_req),
        .ir_load(ir_load), .alu_start(alu_start), .mem_req(mem_req), .mem_we(mem_we),
        .reg_we(reg_we), .pc_step(pc_step), .busy(busy), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [7:0] outs_now();
        return {ir_load, alu_start, mem_req, mem_we, reg_we, pc_step, busy, fetch_req};
    endfunction

    // Monitor: quiet in IDLE/FETCH, otherwise every active cycle must match
    // the front of the expected-trace queue.
    always @(negedge clk) begin
        exp_t e;
        if (state == IDLE || state == FETCH) begin
            chk("quiet_outs", {26'd0, outs_now() & 8'hFC}, 32'd0);
        end else if (exp_q.size() == 0) begin
            chk("unexpected_activity_state", {29'd0, state}, {29'd0, FETCH});
        end else begin
            e = exp_q.pop_front();
            chk("trace_state", {29'd0, state}, {29'd0, e.st});
            chk("trace_outs", {24'd0, outs_now()}, {24'd0, e.outs});
            chk("trace_retired", retired, e.ret);
        end
    end

    function automatic step_t mk(input logic [2:0] st, input logic [7:0] o,
                                 input logic ad, input logic mr);
        step_t s;
        s.st = st; s.outs = o; s.ad = ad; s.mr = mr;
        return s;
    endfunction

    // Called one delta after a posedge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int kind, input int alu_wait,
                             input int mem_wait, input int abort_after, input int halt_at);
        step_t plan[$];
        exp_t  e;
        int    n;
        plan.push_back(mk(DECODE, O_IRL | O_BSY, 1'b0, 1'b0));
        if (kind != K_JAL && kind != K_ONE)
            for (int i = 0; i <= alu_wait; i++)
                plan.push_back(mk(EXEC, O_BSY | ((i == 0) ? O_ALU : 8'h00), i == alu_wait, 1'b1));
        if (kind == K_LOAD || kind == K_STORE)
            for (int i = 0; i <= mem_wait; i++)
                plan.push_back(mk(MEM, O_BSY | O_MRQ | ((kind == K_STORE) ? O_MWE : 8'h00),
                                  1'b1, i == mem_wait));
        if (kind == K_ALU || kind == K_LOAD)
            plan.push_back(mk(WB, O_BSY | O_RWE, 1'b0, 1'b0));
        if (kind == K_BR || kind == K_JAL)
            plan.push_back(mk(PC1, O_BSY | O_PCS, 1'b0, 1'b0));
        plan.push_back(mk(PC2, O_BSY | O_PCS, 1'b0, 1'b0));

        n = (abort_after >= 0) ? abort_after : plan.size();
        for (int k = 0; k < n; k++) begin
            e.st = plan[k].st; e.outs = plan[k].outs; e.ret = exp_ret;
            exp_q.push_back(e);
        end

        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            alu_done  = plan[k].ad;
            mem_ready = plan[k].mr;
            if (k == halt_at) halt = 1'b1;
            if (abort_after >= 0 && k == n - 1) rst = 1'b1;
            @(posedge clk); #1;
        end
        alu_done  = 1'b0;
        mem_ready = 1'b0;
        if (abort_after >= 0) exp_ret = 0;
        else exp_ret = exp_ret + 1;
    endtask

    task automatic after_instr(input string name);
        chk({name, "_state"}, {29'd0, state}, {29'd0, FETCH});
        chk({name, "_fetch_req"}, {31'd0, fetch_req}, 32'd1);
        chk({name, "_retired"}, retired, exp_ret);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        alu_done = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, state}, {29'd0, IDLE});
        chk("reset_outs", {24'd0, outs_now()}, 32'd0);
        chk("reset_retired", retired, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_fetch_state", {29'd0, state}, {29'd0, FETCH});
        chk("first_fetch_outs", {24'd0, outs_now()}, {24'd0, O_FRQ | O_BSY});

        run_instr(32'h00221820, K_ALU,   1, 0, -1, -1); after_instr("add");
        run_instr(32'h10220004, K_BR,    1, 0, -1, -1); after_instr("beq");
        run_instr(32'h0C000010, K_JAL,   0, 0, -1, -1); after_instr("jal");
        run_instr(32'h8C220008, K_LOAD,  0, 3, -1, -1); after_instr("lw");
        run_instr(32'hAC220008, K_STORE, 2, 0, -1, -1); after_instr("sw");
        run_instr(32'h08000004, K_ONE,   0, 0, -1, -1); after_instr("j");
        run_instr(32'h20220005, K_ALU,   0, 0, -1, -1); after_instr("addi");
        run_instr(32'h03E00008, K_BR,    0, 0, -1, -1); after_instr("jr");
        run_instr(32'h0020F809, K_BR,    2, 0, -1, -1); after_instr("jalr");
        run_instr(32'hFC000000, K_ONE,   0, 0, -1, -1); after_instr("illegal");

        // halt raised in WB: PC2 completes, then FETCH sits quiet
        run_instr(32'h00221820, K_ALU, 0, 0, -1, 2);
        chk("halt_state", {29'd0, state}, {29'd0, FETCH});
        chk("halt_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_retired", retired, exp_ret);
        instr_valid = 1'b1;
        instr = 32'h00221820;
        repeat (2) begin @(posedge clk); #1; end
        chk("halt_wins_state", {29'd0, state}, {29'd0, FETCH});
        instr_valid = 1'b0;
        halt = 1'b0;
        @(posedge clk); #1;
        chk("unhalt_fetch_req", {31'd0, fetch_req}, 32'd1);
        chk("unhalt_busy", {31'd0, busy}, 32'd1);

        // reset during MEM abandons the load
        run_instr(32'h8C220008, K_LOAD, 0, 5, 4, -1);
        chk("abort_state", {29'd0, state}, {29'd0, IDLE});
        chk("abort_outs", {24'd0, outs_now()}, 32'd0);
        chk("abort_retired", retired, 32'd0);
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_no_step", {31'd0, pc_step}, 32'd0);
        after_instr("post_abort");
        run_instr(32'h08000004, K_ONE, 0, 0, -1, -1); after_instr("post_abort_j");

        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
